// File: rtl/npu_wb_sequencer.sv
// npu_wb_sequencer: Wishbone classic initiator that runs one NPU job.
// Sequence: 9 weight writes, n_rows row writes, 3*n_rows result reads.
// Optional ack watchdog: define NPU_SEQ_TIMEOUT_EN.
module npu_wb_sequencer #(
  parameter logic [23:0] W_PAGE   = 24'h3000_00,
  parameter logic [23:0] S_PAGE   = 24'h3000_01,
  parameter logic [23:0] R_PAGE   = 24'h3000_02,
  parameter int          N_WGT    = 9,
  parameter int          MAX_ROWS = 85,
  parameter int          TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [7:0]  n_rows_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  output logic [31:0] r_data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [8:0] L_NWGT = 9'(N_WGT);
  localparam logic [7:0] L_MAXR = 8'(MAX_ROWS);

  typedef enum logic [2:0] {IDLE, WGT, ROW, RD, DONE} state_t;

  state_t      r_state;
  logic        r_busy, r_done, r_err;
  logic        r_cyc, r_we, r_rvalid;
  logic [31:0] r_adr, r_dat, r_rdata;
  logic [8:0]  r_idx;    // beat index; 9 bits so "one past 255" is representable
  logic [8:0]  r_total;  // 3*n_rows, last result index
  logic [7:0]  r_nrows;

  logic w_ack, w_s_ready, w_accept, w_timeout;

  // ack only counts while our cycle is open
  assign w_ack = r_cyc & wbm_ack_i;

  // a beat is held exactly while its bus cycle is open, so !r_cyc means no beat held
  assign w_s_ready = !r_cyc &&
                     ((r_state == WGT && r_idx < L_NWGT) ||
                      (r_state == ROW && r_idx < {1'b0, r_nrows}));
  assign w_accept  = w_s_ready & s_valid_i;

`ifdef NPU_SEQ_TIMEOUT_EN
  logic [7:0] r_tcnt;
  assign w_timeout = r_cyc && !wbm_ack_i && (r_tcnt == 8'(TIMEOUT - 1));

  // watchdog: counts cycles of an open bus cycle, cleared by ack or idle bus
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                r_tcnt <= 8'h00;
    else if (!r_cyc || wbm_ack_i)  r_tcnt <= 8'h00;
    else                           r_tcnt <= r_tcnt + 8'h01;
  end
`else
  logic [7:0] w_unused_tmo;
  assign w_unused_tmo = 8'(TIMEOUT);
  assign w_timeout    = 1'b0;
`endif

  // job FSM with all bus/stream outputs registered
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_rvalid <= 1'b0;
      r_adr    <= 32'h0;
      r_dat    <= 32'h0;
      r_rdata  <= 32'h0;
      r_idx    <= 9'h0;
      r_total  <= 9'h0;
      r_nrows  <= 8'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_rvalid && r_ready_i) r_rvalid <= 1'b0;

      if (w_timeout) begin
        r_cyc    <= 1'b0;
        r_err    <= 1'b1;
        r_busy   <= 1'b0;
        r_rvalid <= 1'b0;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              if (n_rows_i > L_MAXR) begin
                r_err <= 1'b1;
              end else begin
                r_state <= WGT;
                r_busy  <= 1'b1;
                r_idx   <= 9'h0;
                r_nrows <= n_rows_i;
                r_total <= {1'b0, n_rows_i} + {n_rows_i, 1'b0};
              end
            end
          end
          WGT: begin
            if (w_accept) begin
              r_cyc <= 1'b1;
              r_we  <= 1'b1;
              r_adr <= {W_PAGE, r_idx[7:0]};
              r_dat <= s_data_i;
              r_idx <= r_idx + 9'h1;
            end else if (w_ack) begin
              r_cyc <= 1'b0;
              if (r_idx == L_NWGT) begin
                r_idx <= 9'h0;
                if (r_nrows == 8'h0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ROW;
                end
              end
            end
          end
          ROW: begin
            if (w_accept) begin
              r_cyc <= 1'b1;
              r_we  <= 1'b1;
              r_adr <= {S_PAGE, 8'h00};
              r_dat <= s_data_i;
              r_idx <= r_idx + 9'h1;
            end else if (w_ack) begin
              r_cyc <= 1'b0;
              if (r_idx == {1'b0, r_nrows}) begin
                r_idx   <= 9'h1;  // result indices start at 1
                r_state <= RD;
              end
            end
          end
          RD: begin
            if (w_ack) begin
              r_cyc    <= 1'b0;
              r_rvalid <= 1'b1;
              r_rdata  <= wbm_dat_i;
              r_idx    <= r_idx + 9'h1;
            end else if (!r_cyc && !r_rvalid) begin
              // next read only once the single result buffer is empty
              if (r_idx > r_total) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_cyc <= 1'b1;
                r_we  <= 1'b0;
                r_adr <= {R_PAGE, r_idx[7:0]};
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign s_ready_o = w_s_ready;
  assign r_valid_o = r_rvalid;
  assign r_data_o  = r_rdata;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_sel_o = {4{r_cyc}};
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule
